// File: rtl/pe_array_ctrl_pkg.sv
// params: shared types and helpers for the PE tile sequencer
// Holds the controller state encoding, the job addressing/datatype configuration
// type broadcast to the array, and the drain-length helper.
package params;
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, WB, DONE} ctrl_state_t;
  typedef enum logic [1:0] {FP32, FP16, INT8, INT4} datatype_t;
  typedef struct packed {
    datatype_t  datatype;
    logic [1:0] layout;
  } addrgen_t;
  // skew across both array dimensions plus the corner beat plus MAC pipeline slack
  function automatic int drain_cycles(input int n, input int extra);
    return 2 * (n - 1) + 1 + extra;
  endfunction
endpackage

// File: rtl/pe_array_ctrl_beat_counter.sv
// beat_counter: saturating beat counter with a runtime terminal value
// Ports: clk, rst; i_clear zeroes the count; i_inc advances it; i_term is the
// terminal count; o_last is high while the count equals i_term.
module beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic         o_last
);
  logic [W-1:0] r_cnt;
  assign o_last = r_cnt == i_term;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clear) ? '0 : (i_inc && !o_last) ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences one MAC job on an NxN systolic tile (load, compute, drain, writeback)
// Ports: start/k_len/cfg_type/cfg_mixed issue a job; busy/done report it;
// c_valid/c_ready/pe_we drive the C preload; en_corner/cm_corner inject the compute burst;
// pe_addr_type/pe_mixed broadcast the job config; pe_wben/pe_out_ready/wb_ready/wb_valid
// run the writeback handshake.
module pe_array_ctrl
  import params::*;
#(
  parameter int N           = 4,
  parameter int DEPTH       = 4,
  parameter int KW          = 8,
  parameter int DRAIN_EXTRA = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  addrgen_t      cfg_type,
  input  logic          cfg_mixed,
  output logic          busy,
  output logic          done,
  input  logic          c_valid,
  output logic          c_ready,
  output logic          pe_we,
  output logic          en_corner,
  output logic          cm_corner,
  output addrgen_t      pe_addr_type,
  output logic          pe_mixed,
  output logic          pe_wben,
  output logic          pe_out_ready,
  input  logic          wb_ready,
  output logic          wb_valid
);
  localparam logic [KW-1:0] DEPTH_LAST = KW'(DEPTH - 1);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(drain_cycles(N, DRAIN_EXTRA) - 1);
  ctrl_state_t   r_state, w_next;
  logic [KW-1:0] r_k, w_term;
  logic          r_mixed, r_wb_valid, w_inc, w_last, w_int4;
  addrgen_t      r_type;
  assign w_int4 = r_type.datatype == INT4;
  always_ff @(posedge clk) begin
    r_state    <= rst ? IDLE : w_next;
    r_wb_valid <= !rst && r_state == WB && wb_ready;
    if (rst) begin
      r_k     <= '0;
      r_type  <= '0;
      r_mixed <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_k     <= k_len;
      r_type  <= cfg_type;
      r_mixed <= cfg_mixed;
    end
  end
  // INT4 stretches the compute count by one so the cm beat lands on the terminal count
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_term = DEPTH_LAST;
    case (r_state)
      IDLE: w_next = start ? LOAD : IDLE;
      LOAD: begin
        w_inc = c_valid;
        if (c_valid && w_last) w_next = r_k == '0 ? DRAIN : COMPUTE;
      end
      COMPUTE: begin
        w_inc  = 1'b1;
        w_term = w_int4 ? r_k : r_k - 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        w_inc  = 1'b1;
        w_term = DRAIN_LAST;
        if (w_last) w_next = WB;
      end
      WB: begin
        w_inc = wb_ready;
        if (wb_ready && w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  beat_counter #(.W(KW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_next != r_state),
    .i_inc   (w_inc),
    .i_term  (w_term),
    .o_last  (w_last)
  );
  assign busy         = r_state != IDLE;
  assign done         = r_state == DONE;
  assign c_ready      = r_state == LOAD;
  assign pe_we        = c_ready && c_valid;
  assign en_corner    = r_state == COMPUTE && !(w_int4 && w_last);
  assign cm_corner    = r_state == COMPUTE && w_int4 && w_last;
  assign pe_wben      = r_state == WB;
  assign pe_out_ready = pe_wben && wb_ready;
  assign wb_valid     = r_wb_valid;
  assign pe_addr_type = r_type;
  assign pe_mixed     = r_mixed;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed and randomized job sequences checked against a timeline model
module tb_pe_array_ctrl;
  import params::*;
  localparam int DEP = 4, D = 9, L = 128;
  localparam int BUSY = 8, DN = 7, CRDY = 6, WE = 5, EN = 4, CM = 3, WBEN = 2, ORDY = 1, VLD = 0;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_mixed = 1'b0, c_valid = 1'b0, wb_ready = 1'b0;
  logic [7:0] k_len = '0;
  addrgen_t cfg_type = '0;
  logic busy, done, c_ready, pe_we, en_corner, cm_corner, pe_mixed, pe_wben, pe_out_ready, wb_valid;
  addrgen_t pe_addr_type;
  bit cv[L], wr[L];
  logic [8:0] e_out[L];
  addrgen_t cur_type = '0;
  bit cur_mx = 1'b0;
  int total = 0, bad = 0;
  int o_done, o_ndn, o_nwe, o_nvld;

  pe_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .cfg_type(cfg_type),
    .cfg_mixed(cfg_mixed), .busy(busy), .done(done), .c_valid(c_valid), .c_ready(c_ready),
    .pe_we(pe_we), .en_corner(en_corner), .cm_corner(cm_corner), .pe_addr_type(pe_addr_type),
    .pe_mixed(pe_mixed), .pe_wben(pe_wben), .pe_out_ready(pe_out_ready), .wb_ready(wb_ready),
    .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d obs=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic fill_ones();
    for (int i = 0; i < L; i++) begin
      cv[i] = 1'b1;
      wr[i] = 1'b1;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < L; i++) begin
      cv[i] = i >= 50 || $urandom_range(0, 3) != 0;
      wr[i] = i >= 50 || $urandom_range(0, 3) != 0;
    end
  endtask

  // Expected per-cycle outputs, laid out phase by phase from the job parameters and handshakes
  task automatic build(input int k, input bit int4, input int rst_at, output int dt);
    int t, acc;
    for (int i = 0; i < L; i++) e_out[i] = '0;
    t = 1;
    acc = 0;
    while (acc < DEP) begin
      e_out[t][BUSY] = 1'b1;
      e_out[t][CRDY] = 1'b1;
      e_out[t][WE]   = cv[t];
      acc += int'(cv[t]);
      t++;
    end
    for (int i = 0; i < k; i++) begin
      e_out[t][BUSY] = 1'b1;
      e_out[t][EN]   = 1'b1;
      t++;
    end
    if (int4 && k > 0) begin
      e_out[t][BUSY] = 1'b1;
      e_out[t][CM]   = 1'b1;
      t++;
    end
    for (int i = 0; i < D; i++) begin
      e_out[t][BUSY] = 1'b1;
      t++;
    end
    acc = 0;
    while (acc < DEP) begin
      e_out[t][BUSY]  = 1'b1;
      e_out[t][WBEN]  = 1'b1;
      e_out[t][ORDY]  = wr[t];
      e_out[t+1][VLD] = wr[t];
      acc += int'(wr[t]);
      t++;
    end
    e_out[t][BUSY] = 1'b1;
    e_out[t][DN]   = 1'b1;
    dt = t;
    if (rst_at >= 0)
      for (int i = rst_at + 1; i < L; i++) e_out[i] = '0;
  endtask

  // Entered just after a clock edge; cycle 0 is the start cycle
  task automatic run(input string tag, input int k, input addrgen_t ty, input bit mx,
                     input int rst_at, input int busy_start_at);
    int dt, last_t;
    logic [8:0] obs;
    logic [4:0] exp_cfg;
    build(k, ty.datatype == INT4, rst_at, dt);
    last_t = rst_at >= 0 ? rst_at + 2 : dt + 2;
    o_done = -1;
    o_ndn  = 0;
    o_nwe  = 0;
    o_nvld = 0;
    for (int t = 0; t <= last_t; t++) begin
      start     = t == 0 || t == busy_start_at;
      k_len     = t == 0 ? 8'(k) : 8'($urandom);
      cfg_type  = t == 0 ? ty : addrgen_t'(4'($urandom));
      cfg_mixed = t == 0 ? mx : 1'($urandom);
      c_valid   = cv[t];
      wb_ready  = wr[t];
      rst       = t == rst_at;
      #3;
      obs = {busy, done, c_ready, pe_we, en_corner, cm_corner, pe_wben, pe_out_ready, wb_valid};
      chk({tag, "_ctrl"}, t, 32'(obs), 32'(e_out[t]));
      exp_cfg = t == 0 ? {cur_type, cur_mx} : (rst_at >= 0 && t > rst_at) ? 5'd0 : {ty, mx};
      chk({tag, "_cfg"}, t, 32'({pe_addr_type, pe_mixed}), 32'(exp_cfg));
      if (done === 1'b1) begin
        o_done = t;
        o_ndn++;
      end
      o_nwe  += int'(pe_we === 1'b1);
      o_nvld += int'(wb_valid === 1'b1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst   = 1'b0;
    cur_type = rst_at >= 0 ? addrgen_t'(0) : ty;
    cur_mx   = rst_at >= 0 ? 1'b0 : mx;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("reset_ctrl", 0, 32'({busy, done, c_ready, pe_we, en_corner, cm_corner, pe_wben, pe_out_ready, wb_valid}), 32'd0);
    chk("reset_cfg", 0, 32'({pe_addr_type, pe_mixed}), 32'd0);
    @(posedge clk);
    #1;

    fill_ones();
    run("fp32", 3, '{datatype: FP32, layout: 2'd0}, 1'b0, -1, -1);
    chk("fp32_done_cyc", 0, o_done, 21);
    chk("fp32_nwe", 0, o_nwe, DEP);
    chk("fp32_nvld", 0, o_nvld, DEP);

    run("int4", 2, '{datatype: INT4, layout: 2'd1}, 1'b0, -1, -1);
    chk("int4_done_cyc", 0, o_done, 21);

    cv[2] = 1'b0;
    cv[3] = 1'b0;
    wr[20] = 1'b0;
    run("bp", 3, '{datatype: FP32, layout: 2'd2}, 1'b0, -1, -1);
    chk("bp_done_cyc", 0, o_done, 24);
    chk("bp_nwe", 0, o_nwe, DEP);
    chk("bp_nvld", 0, o_nvld, DEP);

    fill_ones();
    run("busy_start", 3, '{datatype: INT8, layout: 2'd3}, 1'b1, -1, 10);
    chk("busy_start_done_cyc", 0, o_done, 21);
    chk("busy_start_ndone", 0, o_ndn, 1);

    run("rst_mid", 3, '{datatype: FP16, layout: 2'd1}, 1'b1, 6, -1);
    chk("rst_mid_ndone", 0, o_ndn, 0);
    run("after_rst", 3, '{datatype: FP32, layout: 2'd0}, 1'b0, -1, -1);
    chk("after_rst_done_cyc", 0, o_done, 21);

    run("k0", 0, '{datatype: FP16, layout: 2'd0}, 1'b1, -1, -1);
    chk("k0_done_cyc", 0, o_done, 18);

    for (int j = 0; j < 8; j++) begin
      fill_rand();
      run("rand", $urandom_range(0, 6), addrgen_t'(4'($urandom)), 1'($urandom), -1, -1);
      chk("rand_nwe", j, o_nwe, DEP);
      chk("rand_nvld", j, o_nvld, DEP);
      chk("rand_ndone", j, o_ndn, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
